// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared widths, reset level and fetch state encodings
package if_fetch_ctrl_pkg;

  // Default instruction address and instruction bus widths.
  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W      = 64;

  // Reset is active-low: this is the level of rst that resets the block.
  localparam logic RST_ENABLE = 1'b0;

  // Each ROM word is 8 bytes, so sequential fetch steps the PC by 8.
  localparam int PC_INC = 8;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_RUN  = 2'b01,
    FETCH_HALT = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_fetch_fifo.sv
// rtl/if_fetch_ctrl_fetch_fifo.sv - prefetch FIFO holding {pc, inst} entries
module fetch_fifo
  import if_fetch_ctrl_pkg::*;
#(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid,
  output logic [W-1:0]             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointer and occupancy tracking; flush empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; a push into a full FIFO is only issued alongside a pop, so the slot is free.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch sequencer: PC, ROM access, redirects, prefetch
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS_W,
  parameter int                INST_W   = INST_BUS_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  input  logic              br_flag_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              misalign_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_t       state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next;
  logic               misalign_next;
  logic [CW-1:0]      fifo_count;
  logic               space;
  logic               pop;
  logic [ADDR_W+INST_W-1:0] head;

  fetch_fifo #(
    .W     (ADDR_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (br_flag_i),
    .push      (rom_ce_o),
    .push_data ({pc, rom_inst_i}),
    .pop       (pop),
    .count     (fifo_count),
    .valid     (id_valid_o),
    .head      (head)
  );

  assign id_pc_o   = head[ADDR_W+INST_W-1:INST_W];
  assign id_inst_o = head[INST_W-1:0];

  // A full FIFO still has room when the head leaves in the same cycle.
  assign space = (fifo_count < FULL_COUNT) || (id_valid_o && id_ready_i);
  // A redirect cancels any handshake: the head is flushed rather than consumed.
  assign pop   = id_valid_o && id_ready_i && !br_flag_i;

  // State, PC and trap register updates.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state      <= FETCH_IDLE;
      pc         <= RESET_PC;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      misalign_o <= misalign_next;
    end
  end

  // ROM drive, sequential PC advance and redirect handling (redirect wins over everything).
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    misalign_next = misalign_o;
    rom_ce_o      = 1'b0;
    rom_addr_o    = '0;

    case (state)
      FETCH_IDLE: state_next = FETCH_RUN;
      FETCH_RUN: begin
        rom_addr_o = pc;
        rom_ce_o   = space && !br_flag_i;
      end
      default: state_next = state;
    endcase

    if (rom_ce_o) pc_next = pc + ADDR_W'(PC_INC);

    if (br_flag_i) begin
      pc_next = br_target_i;
      if (br_target_i[2:0] == 3'b000) begin
        state_next    = FETCH_RUN;
        misalign_next = 1'b0;
      end else begin
        state_next    = FETCH_HALT;
        misalign_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - randomized and directed checks of if_fetch_ctrl against a queue model
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [63:0] rom_inst_i;
  logic        br_flag_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [63:0] id_inst_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  // ROM returns its own byte address as the instruction word.
  assign rom_inst_i = {32'b0, rom_addr_o};

  if_fetch_ctrl #(
    .ADDR_W   (32),
    .INST_W   (64),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_o    (rom_ce_o),
    .rom_addr_o  (rom_addr_o),
    .rom_inst_i  (rom_inst_i),
    .br_flag_i   (br_flag_i),
    .br_target_i (br_target_i),
    .id_valid_o  (id_valid_o),
    .id_ready_i  (id_ready_i),
    .id_pc_o     (id_pc_o),
    .id_inst_o   (id_inst_o),
    .misalign_o  (misalign_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of buffered PCs, the next fetch PC, and two mode bits.
  bit          model_on = 1'b0;
  bit          m_gap    = 1'b1;
  bit          m_halted = 1'b0;
  bit          m_mis    = 1'b0;
  logic [31:0] m_pc     = '0;
  logic [31:0] m_q[$];
  bit          m_v;
  bit          m_fetch;
  logic [31:0] m_head;

  always @(negedge clk) begin
    if (model_on) begin
      m_v     = (m_q.size() != 0);
      m_head  = m_v ? m_q[0] : 32'h0;
      m_fetch = !m_gap && !m_halted && !br_flag_i && ((m_q.size() < 4) || (m_v && id_ready_i));
      chk("rom_ce", {63'b0, rom_ce_o}, {63'b0, m_fetch});
      chk("rom_addr", {32'b0, rom_addr_o}, {32'b0, (!m_gap && !m_halted) ? m_pc : 32'h0});
      chk("id_valid", {63'b0, id_valid_o}, {63'b0, m_v});
      chk("id_pc", {32'b0, id_pc_o}, {32'b0, m_head});
      chk("id_inst", id_inst_o, {32'b0, m_head});
      chk("misalign", {63'b0, misalign_o}, {63'b0, m_mis});
      if (!rst) begin
        m_gap = 1'b1; m_halted = 1'b0; m_mis = 1'b0; m_pc = 32'h0; m_q.delete();
      end else if (br_flag_i) begin
        m_q.delete();
        m_pc     = br_target_i;
        m_gap    = 1'b0;
        m_halted = (br_target_i[2:0] != 3'b000);
        m_mis    = m_halted;
      end else begin
        if (m_v && id_ready_i) void'(m_q.pop_front());
        if (m_fetch) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd8;
        end
        m_gap = 1'b0;
      end
    end
  end

  task automatic cyc(input bit r, input bit b, input logic [31:0] t, input bit rd);
    @(posedge clk);
    #1;
    rst = r; br_flag_i = b; br_target_i = t; id_ready_i = rd;
    @(negedge clk);
  endtask

  logic [31:0] rnd_t;
  int          pick;

  initial begin
    @(posedge clk);
    #1 model_on = 1'b1;

    // Reset release with decode always ready.
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("s1_c0_ce", {63'b0, rom_ce_o}, 64'd0);
    chk("s1_c0_valid", {63'b0, id_valid_o}, 64'd0);
    chk("s1_c0_pc", {32'b0, id_pc_o}, 64'd0);
    cyc(1, 0, 0, 1);
    chk("s1_c1_ce", {63'b0, rom_ce_o}, 64'd1);
    chk("s1_c1_addr", {32'b0, rom_addr_o}, 64'h0);
    cyc(1, 0, 0, 1);
    chk("s1_c2_valid", {63'b0, id_valid_o}, 64'd1);
    chk("s1_c2_pc", {32'b0, id_pc_o}, 64'h0);
    chk("s1_c2_addr", {32'b0, rom_addr_o}, 64'h8);
    cyc(1, 0, 0, 1);
    chk("s1_c3_pc", {32'b0, id_pc_o}, 64'h8);
    chk("s1_c3_inst", id_inst_o, 64'h8);

    // Decode stalled from reset: four pushes then the fetch stops.
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0);
      chk("s2_fill_ce", {63'b0, rom_ce_o}, 64'd1);
      chk("s2_fill_addr", {32'b0, rom_addr_o}, 64'(i * 8));
    end
    cyc(1, 0, 0, 0);
    chk("s2_full_ce", {63'b0, rom_ce_o}, 64'd0);
    chk("s2_full_pc", {32'b0, id_pc_o}, 64'h0);
    cyc(1, 0, 0, 1);
    chk("s2_pop_ce", {63'b0, rom_ce_o}, 64'd1);
    chk("s2_pop_addr", {32'b0, rom_addr_o}, 64'h20);
    cyc(1, 0, 0, 1);
    chk("s2_next_pc", {32'b0, id_pc_o}, 64'h8);
    chk("s2_next_addr", {32'b0, rom_addr_o}, 64'h28);

    // Redirect on a full FIFO while decode is ready.
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h100, 1);
    chk("s3_br_ce", {63'b0, rom_ce_o}, 64'd0);
    cyc(1, 0, 0, 1);
    chk("s3_after_addr", {32'b0, rom_addr_o}, 64'h100);
    chk("s3_after_valid", {63'b0, id_valid_o}, 64'd0);
    cyc(1, 0, 0, 1);
    chk("s3_tgt_pc", {32'b0, id_pc_o}, 64'h100);

    // Misaligned redirect halts until a later aligned redirect.
    cyc(1, 1, 32'h104, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1);
      chk("s4_halt_mis", {63'b0, misalign_o}, 64'd1);
      chk("s4_halt_ce", {63'b0, rom_ce_o}, 64'd0);
    end
    cyc(1, 1, 32'h200, 1);
    cyc(1, 0, 0, 1);
    chk("s4_resume_mis", {63'b0, misalign_o}, 64'd0);
    chk("s4_resume_addr", {32'b0, rom_addr_o}, 64'h200);

    // Reset with three buffered entries and a redirect in flight.
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    cyc(0, 1, 32'h304, 0);
    cyc(1, 0, 0, 1);
    chk("s5_valid", {63'b0, id_valid_o}, 64'd0);
    chk("s5_mis", {63'b0, misalign_o}, 64'd0);
    chk("s5_gap_ce", {63'b0, rom_ce_o}, 64'd0);
    cyc(1, 0, 0, 1);
    chk("s5_restart_addr", {32'b0, rom_addr_o}, 64'h0);

    // PC wrap.
    cyc(1, 1, 32'hFFFF_FFF8, 1);
    cyc(1, 0, 0, 1);
    chk("s6_addr0", {32'b0, rom_addr_o}, 64'hFFFF_FFF8);
    cyc(1, 0, 0, 1);
    chk("s6_addr1", {32'b0, rom_addr_o}, 64'h0);
    chk("s6_pc0", {32'b0, id_pc_o}, 64'hFFFF_FFF8);
    cyc(1, 0, 0, 1);
    chk("s6_pc1", {32'b0, id_pc_o}, 64'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      pick  = $urandom_range(0, 3);
      rnd_t = $urandom;
      if (pick == 1) rnd_t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 1) * 8);
      else if (pick >= 2) rnd_t[2:0] = 3'b000;
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 11) == 0, rnd_t,
          $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
